// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment scan display:
//   SEG_BLANK / SEG_DASH  fixed segment patterns (bit6=a ... bit0=g)
//   seg_encode()          nibble -> segment pattern (0-9, anything else blank)
//   state_t               converter FSM states
//   pow10()               constant 10^n, used for the overflow threshold
// ---------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b000_0000;
  localparam logic [6:0] SEG_DASH  = 7'b000_0001;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'b111_1110;
      4'd1:    pat = 7'b011_0000;
      4'd2:    pat = 7'b110_1101;
      4'd3:    pat = 7'b111_1001;
      4'd4:    pat = 7'b011_0011;
      4'd5:    pat = 7'b101_1011;
      4'd6:    pat = 7'b101_1111;
      4'd7:    pat = 7'b111_0000;
      4'd8:    pat = 7'b111_1111;
      4'd9:    pat = 7'b111_1011;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_display_if
// Load handshake between the datapath and the display driver.
//   value_in     binary value to display (master -> slave)
//   value_valid  load strobe, honoured only while busy=0 (master -> slave)
//   busy         conversion in progress (slave -> master)
//   overflow     last accepted value did not fit the digits (slave -> master)
// ---------------------------------------------------------------------------
interface seg7_scan_display_if #(
  parameter int VALUE_W = 32
);
  logic [VALUE_W-1:0] value_in;
  logic               value_valid;
  logic               busy;
  logic               overflow;

  modport master (output value_in, output value_valid, input busy, input overflow);
  modport slave  (input value_in, input value_valid, output busy, output overflow);
endinterface

// File: rtl/seg7_scan_display_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock).
//   clk, rst     clock, synchronous active-high reset
//   value_in     value captured when value_valid=1 and the FSM is idle
//   value_valid  load strobe
//   busy         high for exactly VALUE_W cycles after an accepted load
//   overflow     registered: last accepted value >= 10^DIGITS
//   done         high during the final conversion cycle
//   bcd_result   BCD value that becomes final on the edge ending 'done'
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int VALUE_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value_in,
  input  logic                  value_valid,
  output logic                  busy,
  output logic                  overflow,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_result
);

  localparam int          BCD_W     = 4 * DIGITS;
  localparam int          CNT_W     = $clog2(VALUE_W + 1);
  localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);

  state_t             state_r;
  logic [VALUE_W-1:0] bin_r;
  logic [BCD_W-1:0]   bcd_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               ovf_next_r;

  logic [BCD_W-1:0]   bcd_adj_s;
  logic [BCD_W-1:0]   bcd_shift_s;
  logic               last_step_s;

  // Add-3 correction on every nibble, then shift in the next binary MSB.
  // Bits leaving the top of the accumulator are intentionally dropped.
  always_comb begin
    bcd_adj_s = {BCD_W{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj_s[4*i +: 4] = (bcd_r[4*i +: 4] >= 4'd5) ? (bcd_r[4*i +: 4] + 4'd3)
                                                      : bcd_r[4*i +: 4];
    end
    bcd_shift_s = {bcd_adj_s[BCD_W-2:0], bin_r[VALUE_W-1]};
    last_step_s = (state_r == CONV) && (cnt_r == CNT_W'(1));
  end

  assign done       = last_step_s;
  assign bcd_result = bcd_shift_s;

  // Converter FSM: capture on load, one shift-add-3 step per CONV cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      bin_r      <= {VALUE_W{1'b0}};
      bcd_r      <= {BCD_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      ovf_next_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (value_valid) begin
            bin_r      <= value_in;
            bcd_r      <= {BCD_W{1'b0}};
            cnt_r      <= CNT_W'(VALUE_W);
            ovf_next_r <= (64'(value_in) >= OVF_LIMIT);
            busy       <= 1'b1;
            state_r    <= CONV;
          end
        end
        CONV: begin
          bcd_r <= bcd_shift_s;
          bin_r <= bin_r << 1;
          cnt_r <= cnt_r - CNT_W'(1);
          if (last_step_s) begin
            overflow <= ovf_next_r;
            busy     <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_display.sv
// ---------------------------------------------------------------------------
// seg7_scan_display
// Multi-digit, time-multiplexed seven-segment driver fed by a binary value.
//   clk, rst   clock, synchronous active-high reset
//   load       seg7_scan_display_if.slave: value_in / value_valid / busy / overflow
//   seg        registered segment pattern, active-high, bit6=a ... bit0=g
//   an         registered digit enable, one-hot active-low, bit0 = LSD
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
// ---------------------------------------------------------------------------
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int VALUE_W     = 32,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_display_if.slave  load,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic               done_s;
  logic [BCD_W-1:0]   bcd_result_s;
  logic [BCD_W-1:0]   display_r;
  logic [DIV_W-1:0]   div_r;
  logic [IDX_W-1:0]   idx_r;
  logic [3:0]         nib_s;
  logic [DIGITS-1:0]  lz_blank_s;
  logic               blank_s;
  logic [6:0]         seg_next_s;

  bin2bcd_seq #(
    .DIGITS  (DIGITS),
    .VALUE_W (VALUE_W)
  ) u_conv (
    .clk         (clk),
    .rst         (rst),
    .value_in    (load.value_in),
    .value_valid (load.value_valid),
    .busy        (load.busy),
    .overflow    (load.overflow),
    .done        (done_s),
    .bcd_result  (bcd_result_s)
  );

  // Display register: swapped in whole on the last conversion step.
  always_ff @(posedge clk) begin
    if (rst) begin
      display_r <= {BCD_W{1'b0}};
    end else if (done_s) begin
      display_r <= bcd_result_s;
    end
  end

  // Refresh divider and digit index; index advances on divider wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r <= {DIV_W{1'b0}};
      idx_r <= {IDX_W{1'b0}};
    end else if (div_r == DIV_W'(REFRESH_DIV - 1)) begin
      div_r <= {DIV_W{1'b0}};
      idx_r <= (idx_r == IDX_W'(DIGITS - 1)) ? {IDX_W{1'b0}} : (idx_r + IDX_W'(1));
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // Leading-zero mask: a digit blanks when it and every higher nibble are 0.
  always_comb begin
    lz_blank_s = {DIGITS{1'b0}};
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic higher_zero;
      higher_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        higher_zero   = higher_zero && (display_r[4*i +: 4] == 4'd0);
        lz_blank_s[i] = higher_zero;
      end
    end
`else
    lz_blank_s = {DIGITS{1'b0}};
`endif
  end

  // Select the active digit and choose its pattern (dash wins over blanking).
  always_comb begin
    nib_s   = 4'd0;
    blank_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      nib_s   = (IDX_W'(i) == idx_r) ? display_r[4*i +: 4] : nib_s;
      blank_s = (IDX_W'(i) == idx_r) ? lz_blank_s[i] : blank_s;
    end
    if (load.overflow) begin
      seg_next_s = SEG_DASH;
    end else if (blank_s) begin
      seg_next_s = SEG_BLANK;
    end else begin
      seg_next_s = seg_encode(nib_s);
    end
  end

  // Output registers: seg and an always change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= {DIGITS{1'b1}};
    end else begin
      seg <= seg_next_s;
      an  <= ~(DIGITS'(1) << idx_r);
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_display
// Directed self-checking bench for seg7_scan_display (DIGITS=4, VALUE_W=32,
// REFRESH_DIV=4). Expected digit patterns are queued when a value is loaded
// and popped when the scanned outputs are examined.
// ---------------------------------------------------------------------------
module tb_seg7_scan_display;

  localparam int DIGITS      = 4;
  localparam int VALUE_W     = 32;
  localparam int REFRESH_DIV = 4;

  logic       clk;
  logic       rst;
  logic [6:0] seg;
  logic [3:0] an;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];

  seg7_scan_display_if #(.VALUE_W(VALUE_W)) lif ();

  seg7_scan_display #(
    .DIGITS      (DIGITS),
    .VALUE_W     (VALUE_W),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .load (lif),
    .seg  (seg),
    .an   (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: decimal digit d of v as a segment pattern.
  function automatic logic [6:0] model_seg(input int unsigned v, input int d);
    int unsigned p;
    int unsigned dig;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    if (v >= 10000) return 7'b0000001;
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && v < p) return 7'b0000000;
`endif
    dig = (v / p) % 10;
    case (dig)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      default: return 7'b1111011;
    endcase
  endfunction

  task automatic expect_value(input int unsigned v);
    for (int d = 0; d < DIGITS; d++) exp_q.push_back(model_seg(v, d));
  endtask

  // Pop one value's digit patterns and compare over a full scan period.
  task automatic check_scan(input string tag);
    logic [6:0] expd [DIGITS];
    bit         seen [DIGITS];
    int         idx;
    chk({tag, "_queue"}, 32'(exp_q.size() >= DIGITS), 32'd1);
    for (int d = 0; d < DIGITS; d++) begin
      expd[d] = (exp_q.size() > 0) ? exp_q.pop_front() : 7'bxxxxxxx;
      seen[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      idx = -1;
      for (int d = 0; d < DIGITS; d++) begin
        if (an === ~(4'b0001 << d)) idx = d;
      end
      chk({tag, "_an_onehot"}, 32'(idx >= 0), 32'd1);
      if (idx >= 0) begin
        chk($sformatf("%s_seg_d%0d", tag, idx), 32'(seg), 32'(expd[idx]));
        seen[idx] = 1'b1;
      end
      @(negedge clk);
    end
    for (int d = 0; d < DIGITS; d++) chk($sformatf("%s_seen_d%0d", tag, d), 32'(seen[d]), 32'd1);
  endtask

  // Load v; optionally drive a second strobe or a reset during busy.
  task automatic run_load(input int unsigned v, input int drop_at, input int unsigned drop_v,
                          input int rst_at, output int busy_cycles);
    int n;
    @(negedge clk);
    lif.value_in    = v;
    lif.value_valid = 1'b1;
    @(negedge clk);
    lif.value_valid = 1'b0;
    n = 0;
    while (lif.busy === 1'b1 && n < 100) begin
      n++;
      if (n == drop_at) begin
        lif.value_in    = drop_v;
        lif.value_valid = 1'b1;
      end else begin
        lif.value_valid = 1'b0;
      end
      if (n == rst_at) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        break;
      end
      @(negedge clk);
    end
    lif.value_valid = 1'b0;
    busy_cycles = n;
  endtask

  initial begin
    int bc;
    rst             = 1'b1;
    lif.value_in    = 32'd0;
    lif.value_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(lif.busy), 32'd0);
    chk("rst_overflow", 32'(lif.overflow), 32'd0);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_an", 32'(an), 32'hE);
    chk("post_rst_seg", 32'(seg), 32'(7'b1111110));

    // 1234
    run_load(32'd1234, 0, 0, 0, bc);
    chk("busy_len_1234", 32'(bc), 32'd32);
    chk("ovf_1234", 32'(lif.overflow), 32'd0);
    expect_value(1234);
    check_scan("v1234");

    // Overflow then largest in-range value
    run_load(32'd10000, 0, 0, 0, bc);
    chk("busy_len_10000", 32'(bc), 32'd32);
    chk("ovf_10000", 32'(lif.overflow), 32'd1);
    expect_value(10000);
    check_scan("v10000");
    run_load(32'd9999, 0, 0, 0, bc);
    chk("ovf_9999", 32'(lif.overflow), 32'd0);
    expect_value(9999);
    check_scan("v9999");

    // Leading zeros
    run_load(32'd7, 0, 0, 0, bc);
    chk("busy_len_7", 32'(bc), 32'd32);
    expect_value(7);
    check_scan("v7");

    // Load while busy is dropped
    run_load(32'd42, 10, 32'd99, 0, bc);
    chk("busy_len_42", 32'(bc), 32'd32);
    @(negedge clk);
    chk("no_queue_busy_a", 32'(lif.busy), 32'd0);
    @(negedge clk);
    chk("no_queue_busy_b", 32'(lif.busy), 32'd0);
    expect_value(42);
    check_scan("v42");

    // Reset during conversion
    run_load(32'd5678, 0, 0, 15, bc);
    chk("abort_at", 32'(bc), 32'd15);
    chk("abort_busy", 32'(lif.busy), 32'd0);
    chk("abort_overflow", 32'(lif.overflow), 32'd0);
    expect_value(0);
    check_scan("abort");
    repeat (40) @(negedge clk);
    chk("abort_late_busy", 32'(lif.busy), 32'd0);
    expect_value(0);
    check_scan("abort_late");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
